// File: rtl/mux6_rr_capture.sv
// -----------------------------------------------------------------------------
// mux6_rr_capture
//
// Round-robin controller wrapped around an external 6-bit, 6-to-1 mux.
// It picks one of six requesting sources and drives the mux select.
// One cycle later it captures the mux output into a registered stage.
// The captured word is then offered on a valid/ready handshake.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   req[5:0]   : per-source request, bit i = source i has data on mux input i
//   y_in[5:0]  : mux output, follows sel combinationally
//   out_ready  : consumer accepts out_data when out_valid is also high
//   sel[2:0]   : registered mux select, only ever 0..5
//   grant[5:0] : one-hot acknowledge to the captured source, one-cycle pulse
//   out_data   : registered captured word
//   out_valid  : out_data holds a word not yet accepted
//
// Each transfer walks IDLE -> SELECT -> HOLD.
//   IDLE   : arbitrate among the requests and register sel.
//   SELECT : the mux has settled; capture y_in, raise out_valid and grant.
//   HOLD   : drop grant, then wait for out_ready.
// -----------------------------------------------------------------------------
module mux6_rr_capture (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] req,
   input  logic [5:0] y_in,
   input  logic       out_ready,
   output logic [2:0] sel,
   output logic [5:0] grant,
   output logic [5:0] out_data,
   output logic       out_valid
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t     r_state;
   logic [2:0] r_ptr;        // highest-priority source for the next arbitration
   logic [2:0] r_sel;
   logic [5:0] r_grant;
   logic [5:0] r_out_data;
   logic       r_out_valid;

   // Candidate source for each priority slot: slot 0 is r_ptr and slot 5 is
   // r_ptr-1. All arithmetic is mod 6, so select values 6 and 7 never appear.
   logic [2:0] w_cand [6];
   logic [5:0] w_req_rot;    // req reordered into priority order
   logic [2:0] w_pick;
   logic       w_any_req;
   logic [2:0] w_next_ptr;
   logic [5:0] w_grant_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_cand
         logic [3:0] w_sum;
         assign w_sum         = {1'b0, r_ptr} + 4'(gi);
         assign w_cand[gi]    = (w_sum >= 4'd6) ? 3'(w_sum - 4'd6) : w_sum[2:0];
         assign w_req_rot[gi] = req[w_cand[gi]];
      end
   endgenerate

   // The scan runs from the last slot down to slot 0.
   // The lowest set slot is therefore the one that wins.
   always_comb begin
      w_pick = r_ptr;
      for (int j = 5; j >= 0; j--) begin
         if (w_req_rot[j]) begin
            w_pick = w_cand[j];
         end
      end
   end

   assign w_any_req      = |req;
   assign w_next_ptr     = (r_sel == 3'd5) ? 3'd0 : r_sel + 3'd1;
   assign w_grant_onehot = 6'b000001 << r_sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_ptr       <= 3'd0;
         r_sel       <= 3'd0;
         r_grant     <= 6'd0;
         r_out_data  <= 6'd0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // req is only looked at here.
               // With no request, sel keeps its last value.
               if (w_any_req) begin
                  r_sel   <= w_pick;
                  r_state <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               // Once sel is registered, the transfer is committed.
               // A request withdrawn now still gets captured.
               r_out_data  <= y_in;
               r_out_valid <= 1'b1;
               r_grant     <= w_grant_onehot;
               r_state     <= ST_HOLD;
            end
            ST_HOLD: begin
               r_grant <= 6'd0;
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  // The served source becomes lowest priority next time.
                  r_ptr       <= w_next_ptr;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign sel       = r_sel;
   assign grant     = r_grant;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;

endmodule
